// File: rtl/u409_flash_cycle_pkg.sv
// Shared definitions for the U409 boot-flash cycle controller:
// state encoding, default wait-state timing and the wait counter width.
package u409_pkg;

    localparam int CNT_W = 4;

    localparam int RD_WAIT_DEF      = 4;
    localparam int WR_WAIT_DEF      = 3;
    localparam int HOLD_TIMEOUT_DEF = 15;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDR   = 3'd1,
        STROBE = 3'd2,
        DONE   = 3'd3,
        HOLD   = 3'd4
    } state_t;

endpackage

// File: rtl/u409_flash_cycle_chk.sv
// Property checker for the flash strobes; attach alongside u409_flash_cycle.
module u409_flash_cycle_chk (
    input  logic CLK40_IN,
    input  logic DELAYED_TACK_RST,
    input  logic FLASH_OEn,
    input  logic FLASH_WEn,
    input  logic FLASH_TACK
);

    // Output and write enable must never drive the flash bus at the same time.
    a_oe_we_exclusive: assert property (@(posedge CLK40_IN) disable iff (DELAYED_TACK_RST)
        !(!FLASH_OEn && !FLASH_WEn));

    // The termination request is a single-clock pulse.
    a_tack_one_clock: assert property (@(posedge CLK40_IN) disable iff (DELAYED_TACK_RST)
        FLASH_TACK |=> !FLASH_TACK);

endmodule

// File: rtl/u409_flash_cycle.sv
// Boot-flash cycle controller: decodes a CPU transfer start into flash space,
// drives CEn/OEn/WEn with programmable wait states and requests FLASH_TACK.
module u409_flash_cycle
    import u409_pkg::*;
#(
    parameter int RD_WAIT      = RD_WAIT_DEF,
    parameter int WR_WAIT      = WR_WAIT_DEF,
    parameter int HOLD_TIMEOUT = HOLD_TIMEOUT_DEF
) (
    input  logic CLK40_IN,
    input  logic DELAYED_TACK_RST,
    input  logic TSn,
    input  logic RnW,
    input  logic FLASH_SPACE,
    input  logic WRITE_EN,
    output logic FLASH_CEn,
    output logic FLASH_OEn,
    output logic FLASH_WEn,
    output logic FLASH_TACK,
    output logic WP_HIT,
    output logic BUSY
);

    localparam logic [CNT_W-1:0] RD_WAIT_C      = CNT_W'(RD_WAIT);
    localparam logic [CNT_W-1:0] WR_WAIT_C      = CNT_W'(WR_WAIT);
    localparam logic [CNT_W-1:0] HOLD_TIMEOUT_C = CNT_W'(HOLD_TIMEOUT);

    state_t             state_r,   state_s;
    logic [CNT_W-1:0]   counter_r, counter_s;
    logic [CNT_W-1:0]   wait_s;
    logic               rw_l_r,    rw_l_s;
    logic               ce_n_r,    ce_n_s;
    logic               oe_n_r,    oe_n_s;
    logic               we_n_r,    we_n_s;
    logic               tack_r,    tack_s;
    logic               wp_hit_r,  wp_hit_s;
    logic               busy_r,    busy_s;

    // State, counter and registered outputs; the per-cycle reset tears everything down.
    always_ff @(posedge CLK40_IN or posedge DELAYED_TACK_RST) begin
        if (DELAYED_TACK_RST) begin
            state_r   <= IDLE;
            counter_r <= 4'd0;
            rw_l_r    <= 1'b1;
            ce_n_r    <= 1'b1;
            oe_n_r    <= 1'b1;
            we_n_r    <= 1'b1;
            tack_r    <= 1'b0;
            wp_hit_r  <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            counter_r <= counter_s;
            rw_l_r    <= rw_l_s;
            ce_n_r    <= ce_n_s;
            oe_n_r    <= oe_n_s;
            we_n_r    <= we_n_s;
            tack_r    <= tack_s;
            wp_hit_r  <= wp_hit_s;
            busy_r    <= busy_s;
        end
    end

    // Next-state and next-output logic; the counter serves both the strobe wait and the HOLD guard.
    always_comb begin
        state_s   = state_r;
        counter_s = counter_r;
        rw_l_s    = rw_l_r;
        ce_n_s    = ce_n_r;
        oe_n_s    = oe_n_r;
        we_n_s    = we_n_r;
        tack_s    = tack_r;
        wp_hit_s  = wp_hit_r;
        wait_s    = rw_l_r ? RD_WAIT_C : WR_WAIT_C;

        case (state_r)
            IDLE: begin
                if (!TSn && FLASH_SPACE) begin
                    ce_n_s  = 1'b0;
                    rw_l_s  = RnW;
                    state_s = ADDR;
                end else begin
                    state_s = IDLE;
                end
            end
            ADDR: begin
                if (rw_l_r) begin
                    oe_n_s = 1'b0;
                end else if (WRITE_EN) begin
                    we_n_s = 1'b0;
                end else begin
                    wp_hit_s = 1'b1;
                end
                counter_s = 4'd1;
                state_s   = STROBE;
            end
            STROBE: begin
                wp_hit_s = 1'b0;
                if (counter_r == wait_s) begin
                    tack_s  = 1'b1;
                    we_n_s  = 1'b1;
                    state_s = DONE;
                end else begin
                    counter_s = counter_r + 4'd1;
                end
            end
            DONE: begin
                // CEn/OEn stay low so read data is still driven while the CPU samples TA.
                tack_s    = 1'b0;
                counter_s = 4'd0;
                state_s   = HOLD;
            end
            HOLD: begin
                // Self-release in case TACKn never arrives; TSn is not sampled on this edge.
                if ((counter_r + 4'd1) == HOLD_TIMEOUT_C) begin
                    ce_n_s    = 1'b1;
                    oe_n_s    = 1'b1;
                    we_n_s    = 1'b1;
                    counter_s = 4'd0;
                    state_s   = IDLE;
                end else begin
                    counter_s = counter_r + 4'd1;
                end
            end
            default: begin
                ce_n_s    = 1'b1;
                oe_n_s    = 1'b1;
                we_n_s    = 1'b1;
                tack_s    = 1'b0;
                wp_hit_s  = 1'b0;
                counter_s = 4'd0;
                state_s   = IDLE;
            end
        endcase

        busy_s = (state_s != IDLE);
    end

    assign FLASH_CEn  = ce_n_r;
    assign FLASH_OEn  = oe_n_r;
    assign FLASH_WEn  = we_n_r;
    assign FLASH_TACK = tack_r;
    assign WP_HIT     = wp_hit_r;
    assign BUSY       = busy_r;

endmodule

// File: tb/tb_u409_flash_cycle.sv
// Self-checking bench for u409_flash_cycle: a default instance and an RD_WAIT = 1
// instance share stimulus and are both checked every cycle against a timeline model.
module tb_u409_flash_cycle;

    localparam int WR_W = 3;
    localparam int HT   = 15;

    logic CLK40_IN = 1'b0;
    logic DELAYED_TACK_RST;
    logic TSn, RnW, FLASH_SPACE, WRITE_EN;

    logic ce_a, oe_a, we_a, tack_a, wp_a, busy_a;
    logic ce_b, oe_b, we_b, tack_b, wp_b, busy_b;
    logic [5:0] dut_v [2];

    int n_tests = 0;
    int n_fail  = 0;
    int edge_n  = 0;
    int cur     = 0;
    bit run_chk = 1'b1;

    // Model state per instance: start edge, direction and write unlock of the live cycle
    bit act_m [2] = '{1'b0, 1'b0};
    int s_m   [2] = '{0, 0};
    bit rw_m  [2] = '{1'b1, 1'b1};
    bit en_m  [2] = '{1'b0, 1'b0};

    always #5 CLK40_IN = ~CLK40_IN;

    u409_flash_cycle dut_a (
        .CLK40_IN(CLK40_IN), .DELAYED_TACK_RST(DELAYED_TACK_RST),
        .TSn(TSn), .RnW(RnW), .FLASH_SPACE(FLASH_SPACE), .WRITE_EN(WRITE_EN),
        .FLASH_CEn(ce_a), .FLASH_OEn(oe_a), .FLASH_WEn(we_a),
        .FLASH_TACK(tack_a), .WP_HIT(wp_a), .BUSY(busy_a)
    );

    u409_flash_cycle #(.RD_WAIT(1)) dut_b (
        .CLK40_IN(CLK40_IN), .DELAYED_TACK_RST(DELAYED_TACK_RST),
        .TSn(TSn), .RnW(RnW), .FLASH_SPACE(FLASH_SPACE), .WRITE_EN(WRITE_EN),
        .FLASH_CEn(ce_b), .FLASH_OEn(oe_b), .FLASH_WEn(we_b),
        .FLASH_TACK(tack_b), .WP_HIT(wp_b), .BUSY(busy_b)
    );

    u409_flash_cycle_chk chk_a (
        .CLK40_IN(CLK40_IN), .DELAYED_TACK_RST(DELAYED_TACK_RST),
        .FLASH_OEn(oe_a), .FLASH_WEn(we_a), .FLASH_TACK(tack_a)
    );

    u409_flash_cycle_chk chk_b (
        .CLK40_IN(CLK40_IN), .DELAYED_TACK_RST(DELAYED_TACK_RST),
        .FLASH_OEn(oe_b), .FLASH_WEn(we_b), .FLASH_TACK(tack_b)
    );

    assign dut_v[0] = {ce_a, oe_a, we_a, tack_a, wp_a, busy_a};
    assign dut_v[1] = {ce_b, oe_b, we_b, tack_b, wp_b, busy_b};

    function automatic int rd_w(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic int wait_of(input int i);
        return rw_m[i] ? rd_w(i) : WR_W;
    endfunction

    // Cycle spans edges E0..E(W+1+HT): TACK at E(W+1), HOLD entered at E(W+2), released HT edges later
    function automatic logic [5:0] exp_vec(input int i);
        int t, w;
        logic oe, we, tk, wp;
        w = wait_of(i);
        t = edge_n - s_m[i];
        if (DELAYED_TACK_RST || !act_m[i] || t < 0 || t > w + 1 + HT)
            return 6'b111000;
        oe = !(rw_m[i] && t >= 1);
        we = !(!rw_m[i] && en_m[i] && t >= 1 && t <= w);
        tk = (t == w + 1);
        wp = (!rw_m[i] && !en_m[i] && t == 1);
        return {1'b0, oe, we, tk, wp, 1'b1};
    endfunction

    task automatic check(input string nm, input logic [5:0] got, input logic [5:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %b expected %b", nm, edge_n, got, exp);
        end
    endtask

    // Timeline model: record where a cycle starts and the write unlock seen one edge later
    always @(posedge CLK40_IN) begin
        for (int i = 0; i < 2; i++) begin
            if (DELAYED_TACK_RST) begin
                act_m[i] <= 1'b0;
            end else if (!(act_m[i] && (edge_n - s_m[i]) <= wait_of(i) + 1 + HT)
                         && !TSn && FLASH_SPACE) begin
                act_m[i] <= 1'b1;
                s_m[i]   <= edge_n + 1;
                rw_m[i]  <= RnW;
            end else if (act_m[i] && edge_n == s_m[i]) begin
                en_m[i] <= WRITE_EN;
            end
        end
        edge_n <= edge_n + 1;
    end

    // Every-cycle compare of both instances against the model
    always @(posedge CLK40_IN) begin
        #1;
        if (run_chk) begin
            check("cycle_a", dut_v[0], exp_vec(0));
            check("cycle_b", dut_v[1], exp_vec(1));
        end
    end

    task automatic start(input logic rnw, input logic wen);
        TSn = 1'b0; FLASH_SPACE = 1'b1; RnW = rnw; WRITE_EN = wen;
        @(negedge CLK40_IN);
        TSn = 1'b1; FLASH_SPACE = 1'b0; RnW = 1'b1;
        cur = 0;
    endtask

    task automatic to_edge(input int k);
        repeat (k - cur) @(negedge CLK40_IN);
        cur = k;
    endtask

    task automatic pulse_rst();
        DELAYED_TACK_RST = 1'b1;
        #1;
        check("rst_now_a", dut_v[0], 6'b111000);
        check("rst_now_b", dut_v[1], 6'b111000);
        @(negedge CLK40_IN);
        DELAYED_TACK_RST = 1'b0;
        @(negedge CLK40_IN);
    endtask

    initial begin
        DELAYED_TACK_RST = 1'b1;
        TSn = 1'b1; RnW = 1'b1; FLASH_SPACE = 1'b0; WRITE_EN = 1'b0;
        repeat (2) @(negedge CLK40_IN);
        check("reset_a", dut_v[0], 6'b111000);
        check("reset_b", dut_v[1], 6'b111000);
        DELAYED_TACK_RST = 1'b0;
        @(negedge CLK40_IN);

        // Default read, closed by reset two clocks after TACK
        start(1'b1, 1'b0);
        check("rd_e0_ce_oe", {ce_a, oe_a}, 6'b000001);
        to_edge(1);  check("rd_e1_oe", oe_a, 6'd0);
        to_edge(2);  check("rd1_e2_tack", tack_b, 6'd1);
        to_edge(4);  check("rd_e4_tack", tack_a, 6'd0);
        to_edge(5);  check("rd_e5_tack", tack_a, 6'd1);
        to_edge(6);  check("rd_e6_tack", tack_a, 6'd0);
        to_edge(7);  pulse_rst();

        // Unlocked write; dropping WRITE_EN mid-strobe must not matter
        start(1'b0, 1'b1);
        to_edge(1);  check("wr_e1_we_oe", {we_a, oe_a}, 6'b000001);
        to_edge(2);  WRITE_EN = 1'b0;
        to_edge(3);  check("wr_e3_we", we_a, 6'd0);
        to_edge(4);  check("wr_e4_we_tack", {we_a, tack_a}, 6'b000011);
        to_edge(6);  pulse_rst();

        // Protected write
        start(1'b0, 1'b0);
        to_edge(1);  check("wp_e1_hit_we", {wp_a, we_a}, 6'b000011);
        to_edge(2);  check("wp_e2_hit", wp_a, 6'd0);
        to_edge(4);  check("wp_e4_tack", tack_a, 6'd1);
        to_edge(6);  pulse_rst();

        // Read aborted by reset at E3, fresh cycle sampled at E6
        start(1'b1, 1'b0);
        to_edge(2);
        DELAYED_TACK_RST = 1'b1;
        #1; check("abort_now", dut_v[0], 6'b111000);
        to_edge(3);  DELAYED_TACK_RST = 1'b0;
        to_edge(5);  check("abort_idle", dut_v[0], 6'b111000);
        start(1'b1, 1'b0);
        to_edge(4);  check("abort_e10_tack", tack_a, 6'd0);
        to_edge(5);  check("abort_e11_tack", tack_a, 6'd1);
        to_edge(7);  pulse_rst();

        // Lost TACKn: HOLD self-release, TSn in HOLD and at the timeout edge ignored
        start(1'b1, 1'b0);
        to_edge(10);
        TSn = 1'b0; FLASH_SPACE = 1'b1;
        to_edge(11);
        TSn = 1'b1; FLASH_SPACE = 1'b0;
        to_edge(20); check("lost_e20_busy_ce", {busy_a, ce_a}, 6'b000010);
        TSn = 1'b0; FLASH_SPACE = 1'b1;
        to_edge(21);
        TSn = 1'b1; FLASH_SPACE = 1'b0;
        check("lost_e21_release", dut_v[0], 6'b111000);
        to_edge(23); check("lost_e23_idle", busy_a, 6'd0);
        pulse_rst();

        // Transfer start outside flash space
        TSn = 1'b0; FLASH_SPACE = 1'b0;
        @(negedge CLK40_IN);
        TSn = 1'b1;
        repeat (2) @(negedge CLK40_IN);
        check("nonflash_a", dut_v[0], 6'b111000);
        check("nonflash_b", dut_v[1], 6'b111000);

        run_chk = 1'b0;
        @(negedge CLK40_IN);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
